mx_block_acc_sequencer: RTL

Sequencer for the microscaling accumulator datapath: accepts a stream of MX products (sign, 9-bit exponent, mantissa) over a valid/ready handshake and drives them one per cycle into the combinational BF16 accumulator. It owns the running BF16 accumulator register, marks the first element of every MX block, and counts elements and blocks for a programmed dot-product length. It presents the final BF16 sum on a valid/ready output port. It sits between the PE product stage and the result writeback.

---
 rtl/mx_block_acc_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mx_block_acc_sequencer.sv
// Sequencer for the MX accumulator datapath: feeds products into the combinational
// BF16 adder one per cycle, owns the running sum, and returns it on a valid/ready port.
module mx_block_acc_sequencer #(
    parameter int PROD_WIDTH = 12,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            num_blocks,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [8:0]            in_exp,
    input  logic [PROD_WIDTH-1:0] in_mant,
    output logic                  mx_prod_sign,
    output logic [8:0]            mx_prod_exp,
    output logic [PROD_WIDTH-1:0] mx_prod_mant,
    output logic [15:0]           mx_acc_in,
    output logic                  mx_new_block,
    input  logic [15:0]           mx_acc_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  busy
);

    localparam int EW = $clog2(BLOCK_SIZE);
    localparam logic [EW-1:0] ELEM_LAST = EW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [7:0]      blk_q, blk_d;
    logic [7:0]      nblk_q, nblk_d;

    logic            accept;
    logic            last_elem;
    logic            last_blk;

    assign accept    = (state_q == ST_ACCUM) && in_valid;
    assign last_elem = (elem_q == ELEM_LAST);
    assign last_blk  = (blk_q == (nblk_q - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            elem_q  <= '0;
            blk_q   <= 8'd0;
            nblk_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            elem_q  <= elem_d;
            blk_q   <= blk_d;
            nblk_q  <= nblk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        elem_d  = elem_q;
        blk_d   = blk_q;
        nblk_d  = nblk_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = 16'h0000;
                    // A zero-length dot product skips straight to presenting 0.
                    if (num_blocks != 8'd0) begin
                        nblk_d  = num_blocks;
                        elem_d  = '0;
                        blk_d   = 8'd0;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = mx_acc_out;
                    if (last_elem) begin
                        elem_d = '0;
                        blk_d  = blk_q + 8'd1;
                        if (last_blk) begin
                            state_d = ST_OUT;
                        end
                    end else begin
                        elem_d = elem_q + EW'(1);
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode state only; no path from in_valid or out_ready.
    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_OUT);
    assign busy         = (state_q != ST_IDLE);
    assign out_data     = acc_q;
    assign mx_acc_in    = acc_q;
    assign mx_new_block = (state_q == ST_ACCUM) && (elem_q == '0);
    assign mx_prod_sign = in_sign;
    assign mx_prod_exp  = in_exp;
    assign mx_prod_mant = in_mant;

endmodule
